// File: rtl/bidir_fifo_turnaround_ctrl.sv
// rtl/bidir_fifo_turnaround_ctrl.sv - half-duplex endpoint controller for one side of the bidirectional FIFO
// Streams a TX burst, turns the link around, then streams the RX response back to the user.
module bidir_fifo_turnaround_ctrl #(
  parameter int DSIZE    = 8,
  parameter int LSIZE    = 8,
  parameter int TURN_CYC = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LSIZE-1:0] cmd_tx_len,
  input  logic [LSIZE-1:0] cmd_rx_len,
  input  logic             tx_valid,
  input  logic [DSIZE-1:0] tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [DSIZE-1:0] rx_data,
  input  logic             rx_ready,
  output logic             f_dir,
  output logic             f_winc,
  output logic [DSIZE-1:0] f_wdata,
  input  logic             f_full,
  output logic             f_rinc,
  input  logic [DSIZE-1:0] f_rdata,
  input  logic             f_empty,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_TURN, S_RX} state_t;

  localparam int TW = $clog2(TURN_CYC) + 1;
  localparam int BW = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           r_state, w_state_nxt;
  logic             r_dir, w_dir_nxt;
  logic [LSIZE-1:0] r_tx_left, w_tx_left_nxt;
  logic [LSIZE-1:0] r_rx_left, w_rx_left_nxt;
  logic [TW-1:0]    r_turn_cnt, w_turn_cnt_nxt;
  logic [BW-1:0]    r_blk_cnt, w_blk_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             w_blocked;

  // New commands wait out the done cycle so completion and acceptance never coincide.
  assign cmd_ready = (r_state == S_IDLE) && !r_done;
  assign tx_ready  = (r_state == S_TX) && !f_full;
  assign f_winc    = tx_ready && tx_valid && r_dir;
  assign f_wdata   = tx_data;
  assign rx_valid  = (r_state == S_RX) && !f_empty;
  assign rx_data   = f_rdata;
  assign f_rinc    = rx_valid && rx_ready && !r_dir;
  assign f_dir     = r_dir;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;

  assign w_blocked = ((r_state == S_TX) && f_full) || ((r_state == S_RX) && f_empty);

  always_comb begin
    w_state_nxt    = r_state;
    w_dir_nxt      = r_dir;
    w_tx_left_nxt  = r_tx_left;
    w_rx_left_nxt  = r_rx_left;
    w_turn_cnt_nxt = r_turn_cnt;
    w_blk_cnt_nxt  = '0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          w_tx_left_nxt  = cmd_tx_len;
          w_rx_left_nxt  = cmd_rx_len;
          w_turn_cnt_nxt = '0;
          if (cmd_tx_len != '0) begin
            w_state_nxt = S_TX;
            w_dir_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_TURN;
            w_dir_nxt   = 1'b0;
          end
        end
      end
      S_TX: begin
        if (f_winc && (r_tx_left != '0)) begin
          w_tx_left_nxt = r_tx_left - LSIZE'(1);
          if (r_tx_left == LSIZE'(1)) begin
            w_state_nxt    = S_TURN;
            w_dir_nxt      = 1'b0;
            w_turn_cnt_nxt = '0;
          end
        end
      end
      S_TURN: begin
        if (r_turn_cnt == TURN_LAST) begin
          if (r_rx_left != '0) begin
            w_state_nxt = S_RX;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_turn_cnt_nxt = r_turn_cnt + TW'(1);
        end
      end
      S_RX: begin
        if (f_rinc && (r_rx_left != '0)) begin
          w_rx_left_nxt = r_rx_left - LSIZE'(1);
          if (r_rx_left == LSIZE'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_dir_nxt   = 1'b0;
      end
    endcase

    // Only the FIFO holding us off counts toward the abort; user stalls never do.
    if ((TIMEOUT != 0) && w_blocked && (r_blk_cnt == BLK_LAST)) begin
      w_state_nxt = S_IDLE;
      w_dir_nxt   = 1'b0;
      w_err_nxt   = 1'b1;
      w_done_nxt  = 1'b0;
    end

    if (w_blocked && (w_state_nxt == r_state)) begin
      w_blk_cnt_nxt = (r_blk_cnt == '1) ? r_blk_cnt : r_blk_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_dir      <= 1'b0;
      r_tx_left  <= '0;
      r_rx_left  <= '0;
      r_turn_cnt <= '0;
      r_blk_cnt  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir      <= w_dir_nxt;
      r_tx_left  <= w_tx_left_nxt;
      r_rx_left  <= w_rx_left_nxt;
      r_turn_cnt <= w_turn_cnt_nxt;
      r_blk_cnt  <= w_blk_cnt_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_bidir_fifo_turnaround_ctrl.sv
// tb/tb_bidir_fifo_turnaround_ctrl.sv - directed and randomized bench for bidir_fifo_turnaround_ctrl
// The bench plays both the user and the FIFO peer and predicts each transaction phase by phase.
module tb_bidir_fifo_turnaround_ctrl;

  localparam int DSIZE    = 8;
  localparam int LSIZE    = 8;
  localparam int TURN_CYC = 4;
  localparam int TIMEOUT  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LSIZE-1:0] cmd_tx_len;
  logic [LSIZE-1:0] cmd_rx_len;
  logic             tx_valid;
  logic [DSIZE-1:0] tx_data;
  logic             tx_ready;
  logic             rx_valid;
  logic [DSIZE-1:0] rx_data;
  logic             rx_ready;
  logic             f_dir;
  logic             f_winc;
  logic [DSIZE-1:0] f_wdata;
  logic             f_full;
  logic             f_rinc;
  logic [DSIZE-1:0] f_rdata;
  logic             f_empty;
  logic             busy;
  logic             done;
  logic             err;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bidir_fifo_turnaround_ctrl #(
    .DSIZE(DSIZE), .LSIZE(LSIZE), .TURN_CYC(TURN_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tx_len(cmd_tx_len), .cmd_rx_len(cmd_rx_len),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .f_dir(f_dir), .f_winc(f_winc), .f_wdata(f_wdata), .f_full(f_full),
    .f_rinc(f_rinc), .f_rdata(f_rdata), .f_empty(f_empty),
    .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid  = 1'b0;
    cmd_tx_len = '0;
    cmd_rx_len = '0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    rx_ready   = 1'b0;
    f_full     = 1'b0;
    f_empty    = 1'b1;
    f_rdata    = '0;
  endtask

  // Phases of one transaction as seen from outside: 0 writing, 1 turnaround, 2 reading, 3 completed.
  task automatic run_txn(input int txlen, input int rxlen, input int full_pct, input int empty_pct,
                         input int user_pct, input int rdy_toggle, input int full_lo, input int full_hi);
    logic [DSIZE-1:0] txq[$];
    logic [DSIZE-1:0] rxq[$];
    int phase, tcnt, txk, fstreak, estreak, cyc;
    bit fin, rtog, exp_w, exp_v, exp_r;
    for (int i = 0; i < txlen; i++) txq.push_back(DSIZE'($urandom));
    for (int i = 0; i < rxlen; i++) rxq.push_back(DSIZE'($urandom));
    phase = (txlen != 0) ? 0 : 1;
    tcnt = 0; txk = 0; fstreak = 0; estreak = 0; cyc = 0; fin = 1'b0; rtog = 1'b0;

    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_tx_len = LSIZE'(txlen);
    cmd_rx_len = LSIZE'(rxlen);
    #1;
    chk("cmd_ready_idle", 32'(cmd_ready), 1);
    chk("busy_idle", 32'(busy), 0);

    @(negedge clk);
    while (!fin && cyc < 2000) begin
      cmd_valid  = (phase != 3) && ($urandom_range(0, 3) == 0);
      cmd_tx_len = LSIZE'($urandom);
      cmd_rx_len = LSIZE'($urandom);
      tx_valid   = ($urandom_range(0, 99) < user_pct);
      tx_data    = (txq.size() != 0) ? txq[0] : DSIZE'($urandom);
      if (phase == 0) begin
        txk++;
        f_full = ((txk >= full_lo) && (txk <= full_hi)) ||
                 ((fstreak < 3) && ($urandom_range(0, 99) < full_pct));
        fstreak = f_full ? fstreak + 1 : 0;
      end else begin
        f_full = 1'($urandom);
      end
      if (phase == 2) begin
        f_empty = (estreak < 3) && ($urandom_range(0, 99) < empty_pct);
        estreak = f_empty ? estreak + 1 : 0;
      end else begin
        f_empty = 1'($urandom);
      end
      f_rdata  = (rxq.size() != 0) ? rxq[0] : DSIZE'($urandom);
      rtog     = ~rtog;
      rx_ready = (rdy_toggle != 0) ? rtog : ($urandom_range(0, 99) < user_pct);
      #1;
      if (phase != 3) begin
        chk("busy_active", 32'(busy), 1);
        chk("done_quiet", 32'(done), 0);
        chk("err_quiet", 32'(err), 0);
        chk("cmd_ready_busy", 32'(cmd_ready), 0);
      end
      case (phase)
        0: begin
          exp_w = tx_valid && !f_full;
          chk("tx_dir", 32'(f_dir), 1);
          chk("tx_ready", 32'(tx_ready), 32'(!f_full));
          chk("tx_winc", 32'(f_winc), 32'(exp_w));
          chk("tx_no_rinc", 32'(f_rinc), 0);
          if (exp_w) begin
            chk("tx_wdata", 32'(f_wdata), 32'(txq[0]));
            void'(txq.pop_front());
            if (txq.size() == 0) begin
              phase = 1;
              tcnt  = 0;
            end
          end
        end
        1: begin
          chk("turn_dir", 32'(f_dir), 0);
          chk("turn_no_winc", 32'(f_winc), 0);
          chk("turn_no_rinc", 32'(f_rinc), 0);
          chk("turn_no_rxv", 32'(rx_valid), 0);
          tcnt++;
          if (tcnt == TURN_CYC) phase = (rxlen != 0) ? 2 : 3;
        end
        2: begin
          exp_v = !f_empty;
          exp_r = exp_v && rx_ready;
          chk("rx_dir", 32'(f_dir), 0);
          chk("rx_valid", 32'(rx_valid), 32'(exp_v));
          chk("rx_no_winc", 32'(f_winc), 0);
          chk("rx_rinc", 32'(f_rinc), 32'(exp_r));
          if (exp_v) chk("rx_data", 32'(rx_data), 32'(rxq[0]));
          if (exp_r) begin
            void'(rxq.pop_front());
            if (rxq.size() == 0) phase = 3;
          end
        end
        default: begin
          chk("done_pulse", 32'(done), 1);
          chk("done_no_err", 32'(err), 0);
          chk("done_idle", 32'(busy), 0);
          chk("done_dir", 32'(f_dir), 0);
          fin = 1'b1;
        end
      endcase
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("txn_cycle_budget", 0, 1);

    @(negedge clk);
    idle_inputs();
    #1;
    chk("after_done_ready", 32'(cmd_ready), 1);
    chk("after_done_single", 32'(done), 0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_dir", 32'(f_dir), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_winc", 32'(f_winc), 0);
    chk("rst_rinc", 32'(f_rinc), 0);
    chk("rst_tx_ready", 32'(tx_ready), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_txn(3, 2, 0, 0, 100, 0, 0, -1);
    run_txn(0, 0, 0, 0, 100, 0, 0, -1);
    run_txn(4, 0, 0, 0, 100, 0, 2, 5);
    run_txn(0, 6, 0, 0, 100, 1, 0, -1);

    // Timeout: the FIFO never produces the single response word.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_tx_len = LSIZE'(0);
    cmd_rx_len = LSIZE'(1);
    f_empty    = 1'b1;
    rx_ready   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < TURN_CYC + TIMEOUT; i++) begin
      #1;
      chk("to_wait_err", 32'(err), 0);
      chk("to_wait_busy", 32'(busy), 1);
      chk("to_wait_rinc", 32'(f_rinc), 0);
      @(negedge clk);
    end
    #1;
    chk("to_err_pulse", 32'(err), 1);
    chk("to_no_done", 32'(done), 0);
    chk("to_idle", 32'(busy), 0);
    chk("to_dir", 32'(f_dir), 0);
    @(negedge clk);
    #1;
    chk("to_err_single", 32'(err), 0);
    chk("to_done_never", 32'(done), 0);

    // Reset in the middle of a 5-word write burst.
    @(negedge clk);
    idle_inputs();
    cmd_valid  = 1'b1;
    cmd_tx_len = LSIZE'(5);
    cmd_rx_len = LSIZE'(3);
    @(negedge clk);
    cmd_valid = 1'b0;
    tx_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tx_data = DSIZE'($urandom);
      #1;
      chk("mid_tx_winc", 32'(f_winc), 1);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_dir", 32'(f_dir), 0);
    chk("mid_rst_ready", 32'(cmd_ready), 1);
    chk("mid_rst_winc", 32'(f_winc), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    run_txn(2, 2, 0, 0, 100, 0, 0, -1);

    for (int k = 0; k < 10; k++) begin
      run_txn($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 40),
              $urandom_range(0, 40), $urandom_range(50, 100), 0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
